// File: rtl/wb_sram_target_pkg.sv
// ----------------------------------------------------------------------------
// wb_sram_target_pkg : shared types and constants for the Wishbone SRAM target
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wb_sram_target_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int WAIT_CNT_WIDTH = 4;

  // Number of byte lanes for a given data width.
  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_sram_target.sv
// ----------------------------------------------------------------------------
// wb_sram_target : Wishbone classic target driving a 1-cycle-latency SRAM macro
// Optional address range check: WB_SRAM_TGT_RANGE_CHECK_EN
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_sram_target
  import wb_sram_target_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int WAIT_STATES    = 0,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADR     = 32'h3000_0000,
  parameter logic [WB_ADDR_WIDTH-1:0] ADR_CHK_MASK = 32'hFFFF_FC00
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WB_ADDR_WIDTH-1:0]    adr,
  input  logic [WB_DATA_WIDTH-1:0]    dat_w,
  output logic [WB_DATA_WIDTH-1:0]    dat_r,
  input  logic                        cyc,
  input  logic                        stb,
  input  logic [WB_DATA_WIDTH/8-1:0]  sel,
  input  logic                        we,
  output logic                        ack,
  output logic                        err,
  output logic                        mem_csb,
  output logic                        mem_web,
  output logic [WB_DATA_WIDTH/8-1:0]  mem_wmask,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [WB_DATA_WIDTH-1:0]    mem_din,
  input  logic [WB_DATA_WIDTH-1:0]    mem_dout
);

  localparam int SEL_WIDTH = sel_width(WB_DATA_WIDTH);

  state_t                     state, state_n;
  logic [WAIT_CNT_WIDTH-1:0]  cnt, cnt_n;
  logic                       we_q, we_n;
  logic                       ack_n, err_n, csb_n, web_n;
  logic [WB_DATA_WIDTH-1:0]   dat_r_n, din_n;
  logic [SEL_WIDTH-1:0]       wmask_n;
  logic [MEM_ADDR_WIDTH-1:0]  addr_n;
  logic                       addr_hit;

`ifdef WB_SRAM_TGT_RANGE_CHECK_EN
  assign addr_hit = (adr & ADR_CHK_MASK) == (BASE_ADR & ADR_CHK_MASK);
`else
  // Without the range check every address aliases into the SRAM.
  assign addr_hit = 1'b1;
`endif

  // Bits that only matter for some builds are folded here to keep lint quiet.
  logic unused_ok;
  assign unused_ok = ^{adr[WB_ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], adr[1:0],
                       BASE_ADR, ADR_CHK_MASK};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      dat_r     <= '0;
      mem_csb   <= 1'b1;
      mem_web   <= 1'b1;
      mem_wmask <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      we_q      <= we_n;
      ack       <= ack_n;
      err       <= err_n;
      dat_r     <= dat_r_n;
      mem_csb   <= csb_n;
      mem_web   <= web_n;
      mem_wmask <= wmask_n;
      mem_addr  <= addr_n;
      mem_din   <= din_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = we_q;
    ack_n   = ack;
    err_n   = err;
    dat_r_n = dat_r;
    csb_n   = mem_csb;
    web_n   = mem_web;
    wmask_n = mem_wmask;
    addr_n  = mem_addr;
    din_n   = mem_din;

    case (state)
      IDLE: begin
        if (cyc && stb) begin
          if (!addr_hit) begin
            // Error path reuses ACK purely as the one-cycle termination slot.
            err_n   = 1'b1;
            state_n = ACK;
          end else begin
            csb_n   = 1'b0;
            web_n   = ~we;
            addr_n  = adr[MEM_ADDR_WIDTH+1:2];
            din_n   = dat_w;
            wmask_n = we ? sel : '0;
            cnt_n   = WAIT_CNT_WIDTH'(WAIT_STATES);
            we_n    = we;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        csb_n   = 1'b1;
        web_n   = 1'b1;
        wmask_n = '0;
        state_n = cyc ? WAIT : GAP;
      end
      WAIT: begin
        if (!cyc) begin
          state_n = GAP;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          ack_n   = 1'b1;
          dat_r_n = we_q ? '0 : mem_dout;
          state_n = ACK;
        end
      end
      ACK: begin
        ack_n   = 1'b0;
        err_n   = 1'b0;
        dat_r_n = '0;
        state_n = GAP;
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
